adda_trig_capture: RTL

Bus-tap capture controller sitting directly downstream of the ChipScope VIO trigger stage. Consumes the host-programmed trigger word and packet count, watches the tapped address/data bus, and after a trigger hit forwards the configured number of transactions into the capture FIFO. The FIFO is then drained to the debug host over JTAG.

---
 rtl/adda_pkg.sv | 30 +++
 rtl/adda_trig_match.sv | 32 +++
 rtl/adda_trig_capture.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/adda_pkg.sv
// rtl/adda_pkg.sv - shared constants, FSM encoding and helpers for the bus-tap capture controller
package adda_pkg;

    localparam int TRIG_W       = 56;
    localparam int PNUM_W       = 10;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int OVF_W        = 8;

    // Trigger word layout: {data_match[23:0], addr_match[31:0]}
    localparam int ADDR_LSB     = 0;
    localparam int DATA_LSB     = 32;
    localparam int DATA_MATCH_W = 24;

    // Captured record: {wr, rd, addr, data}
    localparam int CAP_W        = 2 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    // Saturating increment for the overflow counter.
    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == {OVF_W{1'b1}}) ? v : v + {{(OVF_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/adda_trig_match.sv
// rtl/adda_trig_match.sv - combinational trigger comparator with data-wildcard rule
//
// Ports:
//   addr  - registered tapped address
//   data  - low DATA_MATCH_W bits of the registered tapped data
//   trig  - trigger word {data_match, addr_match}
//   hit   - address matches and (data matches or data field is zero)
module adda_trig_match
    import adda_pkg::*;
#(
    parameter int addr_width = ADDR_W,
    parameter int trig_width = TRIG_W
) (
    input  logic [addr_width-1:0]   addr,
    input  logic [DATA_MATCH_W-1:0] data,
    input  logic [trig_width-1:0]   trig,
    output logic                    hit
);

    logic [addr_width-1:0]   trig_addr;
    logic [DATA_MATCH_W-1:0] trig_data;
    logic                    addr_eq;
    logic                    data_ok;

    assign trig_addr = trig[ADDR_LSB +: addr_width];
    assign trig_data = trig[DATA_LSB +: DATA_MATCH_W];
    assign addr_eq   = (addr == trig_addr);
    // An all-zero data field means "match any data".
    assign data_ok   = (trig_data == '0) || (data == trig_data);
    assign hit       = addr_eq && data_ok;

endmodule

// File: rtl/adda_trig_capture.sv
// rtl/adda_trig_capture.sv - trigger-armed bus-tap capture controller feeding the capture FIFO
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   trig_in, pnum_in    - trigger word and window length (0 = disarm) from the VIO stage
//   bus_addr, bus_data  - tapped bus
//   bus_wr, bus_rd      - one-cycle transaction strobes
//   cap_full            - capture FIFO full
//   cap_valid, cap_data - FIFO write strobe and record {wr, rd, addr, data}
//   cap_cnt, ovf_cnt    - transactions consumed in the window, dropped transactions (saturating)
//   state_out, done     - FSM status
module adda_trig_capture
    import adda_pkg::*;
#(
    parameter int trig_width = TRIG_W,
    parameter int pnum_width = PNUM_W,
    parameter int addr_width = ADDR_W,
    parameter int data_width = DATA_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [trig_width-1:0]            trig_in,
    input  logic [pnum_width-1:0]            pnum_in,
    input  logic [addr_width-1:0]            bus_addr,
    input  logic [data_width-1:0]            bus_data,
    input  logic                             bus_wr,
    input  logic                             bus_rd,
    input  logic                             cap_full,
    output logic                             cap_valid,
    output logic [2+addr_width+data_width-1:0] cap_data,
    output logic [pnum_width-1:0]            cap_cnt,
    output logic [OVF_W-1:0]                 ovf_cnt,
    output logic [1:0]                       state_out,
    output logic                             done
);

    // Stage 0: input register
    logic [addr_width-1:0] s0_addr;
    logic [data_width-1:0] s0_data;
    logic                  s0_wr;
    logic                  s0_rd;
    logic                  s0_txn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_addr <= '0;
            s0_data <= '0;
            s0_wr   <= 1'b0;
            s0_rd   <= 1'b0;
        end else begin
            s0_addr <= bus_addr;
            s0_data <= bus_data;
            s0_wr   <= bus_wr;
            s0_rd   <= bus_rd;
        end
    end

    // Simultaneous wr and rd is a single transaction carrying both flags.
    assign s0_txn = s0_wr | s0_rd;

    // Stage 1: match + FSM
    logic hit;

    adda_trig_match #(
        .addr_width (addr_width),
        .trig_width (trig_width)
    ) u_match (
        .addr (s0_addr),
        .data (s0_data[DATA_MATCH_W-1:0]),
        .trig (trig_in),
        .hit  (hit)
    );

    state_t                state;
    state_t                nxt_state;
    logic [pnum_width-1:0] pnum_q;
    logic [pnum_width-1:0] cnt_inc;
    logic                  pnum_zero;
    logic                  arm;
    logic                  cap_evt;

    assign pnum_zero = (pnum_in == '0);
    assign cnt_inc   = cap_cnt + {{(pnum_width-1){1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state logic. Abort (pnum_in == 0) takes priority over a capture
    // in the same cycle, so the aborting cycle's transaction is dropped.
    always_comb begin
        nxt_state = state;
        arm       = 1'b0;
        cap_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!pnum_zero) begin
                    nxt_state = ST_ARMED;
                    arm       = 1'b1;
                end
            end
            ST_ARMED: begin
                if (pnum_zero) begin
                    nxt_state = ST_IDLE;
                end else if (s0_txn && hit) begin
                    cap_evt   = 1'b1;
                    nxt_state = (cnt_inc == pnum_q) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (pnum_zero) begin
                    nxt_state = ST_IDLE;
                end else if (s0_txn) begin
                    cap_evt = 1'b1;
                    if (cnt_inc == pnum_q) begin
                        nxt_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (pnum_zero) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Registered capture datapath. A transaction dropped on cap_full still
    // advances cap_cnt so the window length stays exact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pnum_q    <= '0;
            cap_cnt   <= '0;
            ovf_cnt   <= '0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= cap_evt & ~cap_full;
            if (arm) begin
                pnum_q  <= pnum_in;
                cap_cnt <= '0;
                ovf_cnt <= '0;
            end
            if (cap_evt) begin
                cap_cnt <= cnt_inc;
                if (cap_full) begin
                    ovf_cnt <= sat_inc(ovf_cnt);
                end else begin
                    cap_data <= {s0_wr, s0_rd, s0_addr, s0_data};
                end
            end
        end
    end

    // Status outputs
    always_comb begin
        state_out = state;
        done      = (state == ST_DONE);
    end

endmodule
